// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core.
// Holds ALU operation codes, primary opcodes and the control bundle (ctrl_t)
// passed from the decoder through ID/EX and EX/MEM.
package cpu_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       bne;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (combinational).
// Ports:
//   id_valid, id_jump, id_reg_dst, id_branch, id_mem_write : ID usage inputs
//   id_rs, id_rt                                         : ID source specifiers
//   ex_valid, ex_mem_read, ex_rt                         : instruction in EX
//   hazard                                               : ID consumes EX load result
module hazard_detect (
  input  logic       id_valid,
  input  logic       id_jump,
  input  logic       id_reg_dst,
  input  logic       id_branch,
  input  logic       id_mem_write,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  logic rs_use;
  logic rt_use;

  // j does not read rs; rt is only read by R-type, branches and stores.
  assign rs_use = id_valid & ~id_jump;
  assign rt_use = id_valid & (id_reg_dst | id_branch | id_mem_write);

  assign hazard = ex_valid & ex_mem_read & (ex_rt != 5'd0) &
                  ((rs_use & (id_rs == ex_rt)) | (rt_use & (id_rt == ex_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble insertion.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   id_*                : decoder control bits, operands and specifiers
//   flush               : squash the ID instruction (taken branch/jump)
//   stall               : hold PC and IF/ID this cycle (combinational)
//   ex_*                : registered copies of the id_* fields
//   bubble_cnt          : saturating count of bubbles inserted for valid ID instrs
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          id_reg_dst,
  input  logic          id_jump,
  input  logic          id_branch,
  input  logic          id_mem_read,
  input  logic          id_mem_to_reg,
  input  logic          id_mem_write,
  input  logic          id_alu_src,
  input  logic          id_reg_write,
  input  logic          id_bne,
  input  logic [3:0]    id_alu_op,
  input  logic [DW-1:0] id_pc4,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic          flush,
  output logic          stall,
  output logic          ex_valid,
  output logic          ex_reg_dst,
  output logic          ex_jump,
  output logic          ex_branch,
  output logic          ex_mem_read,
  output logic          ex_mem_to_reg,
  output logic          ex_mem_write,
  output logic          ex_alu_src,
  output logic          ex_reg_write,
  output logic          ex_bne,
  output logic [3:0]    ex_alu_op,
  output logic [DW-1:0] ex_pc4,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [CW-1:0] bubble_cnt
);

  ctrl_t          id_ctrl;
  ctrl_t          ctrl_d, ctrl_q;
  logic           valid_d, valid_q;
  logic [DW-1:0]  pc4_q, rs_data_q, rt_data_q, imm_q;
  logic [4:0]     rs_q, rt_q, rd_q;
  logic [CW-1:0]  cnt_d, cnt_q;
  logic           hazard;
  logic           bubble;

  assign id_ctrl = '{
    reg_dst:    id_reg_dst,
    jump:       id_jump,
    branch:     id_branch,
    mem_read:   id_mem_read,
    mem_to_reg: id_mem_to_reg,
    mem_write:  id_mem_write,
    alu_src:    id_alu_src,
    reg_write:  id_reg_write,
    bne:        id_bne,
    alu_op:     id_alu_op
  };

  hazard_detect u_hazard_detect (
    .id_valid     (id_valid),
    .id_jump      (id_jump),
    .id_reg_dst   (id_reg_dst),
    .id_branch    (id_branch),
    .id_mem_write (id_mem_write),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_valid     (valid_q),
    .ex_mem_read  (ctrl_q.mem_read),
    .ex_rt        (rt_q),
    .hazard       (hazard)
  );

  // Flush already discards the ID instruction, so there is nothing to hold.
  assign stall  = hazard & ~flush;
  assign bubble = flush | hazard;

  always_comb begin
    ctrl_d  = id_ctrl;
    valid_d = id_valid;
    if (bubble) begin
      // Only side-effecting bits are cleared; the rest pass through untouched.
      valid_d           = 1'b0;
      ctrl_d.reg_write  = 1'b0;
      ctrl_d.mem_read   = 1'b0;
      ctrl_d.mem_write  = 1'b0;
      ctrl_d.branch     = 1'b0;
      ctrl_d.bne        = 1'b0;
      ctrl_d.jump       = 1'b0;
      ctrl_d.mem_to_reg = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bubble && id_valid && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      pc4_q     <= id_pc4;
      rs_data_q <= id_rs_data;
      rt_data_q <= id_rt_data;
      imm_q     <= id_imm;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      rd_q      <= id_rd;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_jump       = ctrl_q.jump;
  assign ex_branch     = ctrl_q.branch;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_bne        = ctrl_q.bne;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_pc4        = pc4_q;
  assign ex_rs_data    = rs_data_q;
  assign ex_rt_data    = rt_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_rd         = rd_q;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int          CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic          id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg;
  logic          id_mem_write, id_alu_src, id_reg_write, id_bne;
  logic [3:0]    id_alu_op;
  logic [DW-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          flush;
  logic          stall;
  logic          ex_valid;
  logic          ex_reg_dst, ex_jump, ex_branch, ex_mem_read, ex_mem_to_reg;
  logic          ex_mem_write, ex_alu_src, ex_reg_write, ex_bne;
  logic [3:0]    ex_alu_op;
  logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [CW-1:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  // Model state: the instruction currently sitting in EX.
  logic          m_valid;
  ctrl_t         m_ctrl;
  logic [127:0]  m_data;
  logic [14:0]   m_spec;
  int            m_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .CW(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_reg_dst    (id_reg_dst),
    .id_jump       (id_jump),
    .id_branch     (id_branch),
    .id_mem_read   (id_mem_read),
    .id_mem_to_reg (id_mem_to_reg),
    .id_mem_write  (id_mem_write),
    .id_alu_src    (id_alu_src),
    .id_reg_write  (id_reg_write),
    .id_bne        (id_bne),
    .id_alu_op     (id_alu_op),
    .id_pc4        (id_pc4),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .flush         (flush),
    .stall         (stall),
    .ex_valid      (ex_valid),
    .ex_reg_dst    (ex_reg_dst),
    .ex_jump       (ex_jump),
    .ex_branch     (ex_branch),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_mem_write  (ex_mem_write),
    .ex_alu_src    (ex_alu_src),
    .ex_reg_write  (ex_reg_write),
    .ex_bne        (ex_bne),
    .ex_alu_op     (ex_alu_op),
    .ex_pc4        (ex_pc4),
    .ex_rs_data    (ex_rs_data),
    .ex_rt_data    (ex_rt_data),
    .ex_imm        (ex_imm),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd),
    .bubble_cnt    (bubble_cnt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_t obs_ctrl();
    ctrl_t c;
    c = '{reg_dst: ex_reg_dst, jump: ex_jump, branch: ex_branch, mem_read: ex_mem_read,
          mem_to_reg: ex_mem_to_reg, mem_write: ex_mem_write, alu_src: ex_alu_src,
          reg_write: ex_reg_write, bne: ex_bne, alu_op: ex_alu_op};
    return c;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_ctrl  = '0;
    m_data  = '0;
    m_spec  = '0;
    m_cnt   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 128'(ex_valid), 128'(m_valid));
    check({tag, ".ctrl"}, 128'(obs_ctrl()), 128'(m_ctrl));
    check({tag, ".data"}, {ex_pc4, ex_rs_data, ex_rt_data, ex_imm}, m_data);
    check({tag, ".spec"}, 128'({ex_rs, ex_rt, ex_rd}), 128'(m_spec));
    check({tag, ".cnt"}, 128'(bubble_cnt), 128'(m_cnt));
  endtask

  // Does the ID instruction read the register a valid EX load is about to write?
  function automatic logic model_hazard(input logic v, input ctrl_t c, input logic [4:0] rs,
                                        input logic [4:0] rt);
    logic [4:0] srcs[$];
    if (!(m_valid && m_ctrl.mem_read && m_spec[9:5] != 5'd0)) return 1'b0;
    if (v && !c.jump) srcs.push_back(rs);
    if (v && (c.reg_dst || c.branch || c.mem_write)) srcs.push_back(rt);
    foreach (srcs[i]) if (srcs[i] == m_spec[9:5]) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: drive ID, check stall, clock, update model, check EX.
  task automatic step(input logic v, input ctrl_t c, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [DW-1:0] imm, input logic fl,
                      output logic st);
    logic          haz;
    logic [DW-1:0] pc4, rsd, rtd;
    pc4 = $urandom; rsd = $urandom; rtd = $urandom;
    id_valid = v;
    {id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src,
     id_reg_write, id_bne, id_alu_op} = c;
    id_pc4 = pc4; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd;
    flush = fl;
    #1;
    haz = model_hazard(v, c, rs, rt);
    st  = stall;
    check("stall", 128'(stall), 128'(haz & ~fl));
    @(posedge clk);
    if (fl || haz) begin
      m_valid = 1'b0;
      m_ctrl  = c;
      m_ctrl.reg_write = 0; m_ctrl.mem_read = 0; m_ctrl.mem_write = 0; m_ctrl.branch = 0;
      m_ctrl.bne = 0; m_ctrl.jump = 0; m_ctrl.mem_to_reg = 0;
      if (v && m_cnt < CntMax) m_cnt++;
    end else begin
      m_valid = v;
      m_ctrl  = c;
    end
    m_data = {pc4, rsd, rtd, imm};
    m_spec = {rs, rt, rd};
    #1;
    check_outputs("step");
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    case ($urandom_range(0, 3))
      0:       r = 5'd0;
      1:       r = 5'd8;
      2:       r = 5'd9;
      default: r = 5'd10;
    endcase
    return r;
  endfunction

  initial begin
    ctrl_t c_addi, c_lw, c_add, c_j, c_rnd;
    logic  st;

    c_addi = '0; c_addi.alu_src = 1; c_addi.reg_write = 1; c_addi.alu_op = ALU_ADD;
    c_lw   = '0; c_lw.mem_read = 1; c_lw.mem_to_reg = 1; c_lw.alu_src = 1; c_lw.reg_write = 1;
    c_add  = '0; c_add.reg_dst = 1; c_add.reg_write = 1; c_add.alu_op = ALU_ADD;
    c_j    = '0; c_j.jump = 1;

    rst_n = 1'b0;
    {id_valid, id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
     id_alu_src, id_reg_write, id_bne, id_alu_op} = '0;
    id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset.stall", 128'(stall), 128'(0));
    rst_n = 1'b1;

    // Pass-through: addi $t1, imm 5
    step(1, c_addi, 5'd0, 5'd9, 5'd0, 32'd5, 0, st);
    check("pt.stall", 128'(st), 128'(0));
    check("pt.rt", 128'(ex_rt), 128'(9));
    check("pt.imm", 128'(ex_imm), 128'(5));
    check("pt.valid", 128'(ex_valid), 128'(1));
    check("pt.regwr", 128'(ex_reg_write), 128'(1));

    // Asynchronous reset mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    check("arst.regwr", 128'(ex_reg_write), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load-use: lw $8 then add $9,$8,$10
    step(1, c_lw, 5'd0, 5'd8, 5'd0, 32'd0, 0, st);
    step(1, c_add, 5'd8, 5'd10, 5'd9, 32'd0, 0, st);
    check("lu.stall", 128'(st), 128'(1));
    check("lu.valid", 128'(ex_valid), 128'(0));
    check("lu.regwr", 128'(ex_reg_write), 128'(0));
    check("lu.cnt", 128'(bubble_cnt), 128'(1));
    step(1, c_add, 5'd8, 5'd10, 5'd9, 32'd0, 0, st);
    check("lu2.stall", 128'(st), 128'(0));
    check("lu2.valid", 128'(ex_valid), 128'(1));
    check("lu2.rs", 128'(ex_rs), 128'(8));

    // lw $0 followed by consumer of $0
    step(1, c_lw, 5'd0, 5'd0, 5'd0, 32'd0, 0, st);
    step(1, c_add, 5'd0, 5'd0, 5'd9, 32'd0, 0, st);
    check("z.stall", 128'(st), 128'(0));
    // lw $8 followed by j with rs field 8
    step(1, c_lw, 5'd0, 5'd8, 5'd0, 32'd0, 0, st);
    step(1, c_j, 5'd8, 5'd8, 5'd0, 32'd0, 0, st);
    check("j.stall", 128'(st), 128'(0));
    // lw $8 followed by addi writing rt=8
    step(1, c_lw, 5'd0, 5'd8, 5'd0, 32'd0, 0, st);
    step(1, c_addi, 5'd1, 5'd8, 5'd0, 32'd3, 0, st);
    check("ai.stall", 128'(st), 128'(0));

    // Hazard and flush together: one bubble, no stall
    step(1, c_lw, 5'd0, 5'd8, 5'd0, 32'd0, 0, st);
    step(1, c_add, 5'd8, 5'd10, 5'd9, 32'd0, 1, st);
    check("fl.stall", 128'(st), 128'(0));
    check("fl.valid", 128'(ex_valid), 128'(0));
    check("fl.cnt", 128'(bubble_cnt), 128'(2));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      c_rnd = ctrl_t'($urandom);
      step($urandom_range(0, 3) != 0, c_rnd, pick_reg(), pick_reg(), pick_reg(), $urandom,
           $urandom_range(0, 7) == 0, st);
    end

    // Saturation after a fresh reset
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("sat0.cnt", 128'(bubble_cnt), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1, c_add, 5'd1, 5'd2, 5'd3, 32'd0, 1, st);
    check("sat.cnt", 128'(bubble_cnt), 128'(4'hF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline stage between instruction decode and execute in the 5-stage MIPS core. It registers the decoder's control bundle together with operand data into the ID/EX pipeline register. It detects load-use hazards against the instruction currently in EX, requests an IF/ID stall, and inserts bubbles on hazard or on branch/jump flush. A saturating bubble counter supports performance debug.

## Interface
Parameters:
- `DW`, 32: datapath width (PC, register data, immediate).
- `CW`, 16: bubble counter width.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  ID holds a real instruction.
- `id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_bne`  in  1 each  decoder control bits.
- `id_alu_op`  in  4  ALU operation code.
- `id_pc4`  in  DW  PC+4 of ID instruction.
- `id_rs_data, id_rt_data`  in  DW  register-file read data.
- `id_imm`  in  DW  sign-extended immediate.
- `id_rs, id_rt, id_rd`  in  5  register specifiers.
- `flush`  in  1  branch/jump resolved taken; squash ID instruction.
- `stall`  out  1  hold PC and IF/ID this cycle (combinational).
- `ex_valid`  out  1  EX holds a real instruction.
- `ex_reg_dst ... ex_bne, ex_alu_op, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd`  out  same widths  registered copies of the `id_*` fields.
- `bubble_cnt`  out  CW  number of bubbles inserted, saturating.

## Operation
- rs-use: `id_valid & ~id_jump`.
- rt-use: `id_valid & (id_reg_dst | id_branch | id_mem_write)`.
- hazard = `ex_valid & ex_mem_read & ex_rt != 0 & ((rs-use & id_rs == ex_rt) | (rt-use & id_rt == ex_rt))`.
- `stall = hazard & ~flush`.
- Next-state priority per edge:
  1. `flush` → bubble.
  2. else `hazard` → bubble.
  3. else → load all `id_*` fields, `ex_valid <= id_valid`.
- Bubble: `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_bne`, `ex_jump`, `ex_mem_to_reg` ← 0. All other fields (`alu_op`, `reg_dst`, `alu_src`, data, specifiers) load from `id_*` unchanged.
- `bubble_cnt` increments on every edge where a bubble is inserted while `id_valid=1`. It holds at all-ones (no wrap).
- A bubble does not create a hazard in the next cycle, because `ex_valid=0`. A stall therefore lasts exactly one cycle per load-use pair.

## Timing
- Reset (async assert, on `rst_n` falling): every `ex_*` output ← 0, `ex_valid` ← 0, `bubble_cnt` ← 0. `stall` evaluates to 0, since `ex_valid=0`.
- Reset release is synchronous to `clk`. The first capture happens on the first rising edge with `rst_n=1`.
- Latency: `id_*` → `ex_*` is one cycle.
- `stall` is valid in the same cycle as the ID inputs. It has no registered delay.
- `flush` together with `hazard` in the same cycle: a single bubble, `stall=0`, and the counter increments once.
- Reset mid-stall: the stall is abandoned and no pending state survives.

## Structure
- Shared package `cpu_pkg` holds:
  - ALU op constants: ADD=4'b0000, SUB=4'b0001, AND=4'b0010, OR=4'b0011, SLT=4'b0111.
  - Opcode constants for R-type, addi, andi, ori, slti, lw, sw, beq, bne, j.
  - Packed struct `ctrl_t` bundling the ten control fields. The decoder, this stage and the EX/MEM register share this struct.
- Sub-module `hazard_detect`: combinational. Inputs: ID usage/specifiers and EX `mem_read`/`rt`/`valid`. Output: `hazard`. All other logic (the register and counter) stays in `id_ex_stage`.

## Test plan
- Reset: drive `rst_n=0` mid-run with `ex_reg_write=1` → all outputs 0 immediately, without waiting for a clock edge.
- Pass-through: addi $t1 (id_rt=9, imm=5, alu_op=0000, alu_src=1, reg_write=1) → next cycle `ex_rt=9`, `ex_imm=5`, `ex_valid=1`, `stall=0`.
- Load-use: lw $8 in EX, followed by add $9,$8,$10 in ID (id_rs=8) → `stall=1` for one cycle. EX gets a bubble (`ex_reg_write=0`, `ex_valid=0`). The add enters EX the next cycle. `bubble_cnt` goes 0→1.
- No false hazard:
  - lw $0 in EX followed by a consumer of $0 → `stall=0`.
  - lw $8 in EX followed by j (id_rs=8) → `stall=0`.
  - lw $8 in EX followed by addi with id_rt=8 → `stall=0`.
- Flush priority: hazard and `flush=1` in the same cycle → `stall=0`, exactly one bubble, `bubble_cnt` +1.
- Saturation: with `CW=4`, force 20 bubbles → `bubble_cnt` stays at 4'hF.
